ram_port_arbiter: RTL and testbench

- Shares the single-port matrix RAM (synchronous read, 1-cycle latency) between two requesters.
  - Requester 0: host loader/readout, which writes operand matrices and the metadata word and reads back results.
  - Requester 1: the matrix-multiply control unit.
- Arbitration is round-robin, with an optional per-requester lock for uninterrupted bursts (operand fetch, 2x2 writeback).
- A lock watchdog force-releases a lock whose owner has gone idle.
- Sits between both requesters and the RAM instance in the multiplier top level.

---
 rtl/ram_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of the single-port matrix RAM.
// Round-robin between the host loader (requester 0) and the multiply
// control unit (requester 1), with optional ownership locks for bursts
// and a watchdog that reclaims a lock whose owner stopped requesting.
module ram_port_arbiter #(
  parameter int data_w       = 32,
  parameter int ram_d        = 512,
  parameter int ram_add_w    = $clog2(ram_d),
  parameter int LOCK_TIMEOUT = 16,
  parameter int to_w         = $clog2(LOCK_TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_i,
  input  logic                 req1_i,
  input  logic                 we0_i,
  input  logic                 we1_i,
  input  logic [ram_add_w-1:0] addr0_i,
  input  logic [ram_add_w-1:0] addr1_i,
  input  logic [data_w-1:0]    wdata0_i,
  input  logic [data_w-1:0]    wdata1_i,
  input  logic                 lock0_i,
  input  logic                 lock1_i,
  output logic                 gnt0_o,
  output logic                 gnt1_o,
  output logic                 rvalid0_o,
  output logic                 rvalid1_o,
  output logic [data_w-1:0]    rdata_o,
  output logic                 ram_we_o,
  output logic [ram_add_w-1:0] ram_addr_o,
  output logic [data_w-1:0]    ram_w_data_o,
  input  logic [data_w-1:0]    ram_r_data_i,
  output logic [1:0]           owner_o,
  output logic                 lock_err_o
);

  // The encoding doubles as the owner output: 00 none, 01 req0, 10 req1.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOCK0 = 2'b01,
    LOCK1 = 2'b10
  } state_t;

  // Watchdog fires on the LOCK_TIMEOUT-th consecutive idle cycle.
  localparam logic [to_w-1:0] WdLast = to_w'(LOCK_TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic                   rLast_q, rLast_d;
  logic [to_w-1:0]        wdCnt_q, wdCnt_d;
  logic                   lockErr_q, lockErr_d;
  logic                   grant0, grant1;
  logic                   ramWe_q;
  logic [ram_add_w-1:0]   ramAddr_q;
  logic [data_w-1:0]      ramWData_q;
  logic                   rdPend0_q, rdPend1_q;
  logic                   rvalid0_q, rvalid1_q;

  // Grant selection, lock/watchdog next state and round-robin history.
  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    state_d   = state_q;
    rLast_d   = rLast_q;
    wdCnt_d   = '0;
    lockErr_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_i && req1_i) begin
          if (rLast_q) grant0 = 1'b1;
          else         grant1 = 1'b1;
        end else if (req0_i) begin
          grant0 = 1'b1;
        end else if (req1_i) begin
          grant1 = 1'b1;
        end
        if (grant0 && lock0_i)      state_d = LOCK0;
        else if (grant1 && lock1_i) state_d = LOCK1;
      end
      LOCK0: begin
        grant0 = req0_i;
        if (!lock0_i) begin
          state_d = IDLE;
        end else if (!req0_i) begin
          if (wdCnt_q == WdLast) begin
            state_d   = IDLE;
            lockErr_d = 1'b1;
            rLast_d   = 1'b0;
          end else begin
            wdCnt_d = wdCnt_q + 1'b1;
          end
        end
      end
      LOCK1: begin
        grant1 = req1_i;
        if (!lock1_i) begin
          state_d = IDLE;
        end else if (!req1_i) begin
          if (wdCnt_q == WdLast) begin
            state_d   = IDLE;
            lockErr_d = 1'b1;
            rLast_d   = 1'b1;
          end else begin
            wdCnt_d = wdCnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant0)      rLast_d = 1'b0;
    else if (grant1) rLast_d = 1'b1;
  end

  // Arbitration state, round-robin history and watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rLast_q   <= 1'b1;
      wdCnt_q   <= '0;
      lockErr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rLast_q   <= rLast_d;
      wdCnt_q   <= wdCnt_d;
      lockErr_q <= lockErr_d;
    end
  end

  // Registered RAM command and the two-stage read-valid pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      ramWe_q    <= 1'b0;
      ramAddr_q  <= '0;
      ramWData_q <= '0;
      rdPend0_q  <= 1'b0;
      rdPend1_q  <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      rdPend0_q <= grant0 && !we0_i;
      rdPend1_q <= grant1 && !we1_i;
      rvalid0_q <= rdPend0_q;
      rvalid1_q <= rdPend1_q;
      if (grant0) begin
        ramWe_q    <= we0_i;
        ramAddr_q  <= addr0_i;
        ramWData_q <= wdata0_i;
      end else if (grant1) begin
        ramWe_q    <= we1_i;
        ramAddr_q  <= addr1_i;
        ramWData_q <= wdata1_i;
      end else begin
        ramWe_q <= 1'b0;
      end
    end
  end

  assign gnt0_o       = grant0;
  assign gnt1_o       = grant1;
  assign rvalid0_o    = rvalid0_q;
  assign rvalid1_o    = rvalid1_q;
  assign rdata_o      = ram_r_data_i;
  assign ram_we_o     = ramWe_q;
  assign ram_addr_o   = ramAddr_q;
  assign ram_w_data_o = ramWData_q;
  assign owner_o      = state_q;
  assign lock_err_o   = lockErr_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: a behavioural RAM, a
// transaction-level reference model, a directed vector table, hand
// sequences for the multi-cycle corners and a randomized phase.
module tb_ram_port_arbiter;

  localparam int DataW       = 32;
  localparam int RamD        = 512;
  localparam int AddrW       = 9;
  localparam int LockTimeout = 16;

  logic             clk, rst;
  logic             req0, req1, we0, we1, lock0, lock1;
  logic [AddrW-1:0] addr0, addr1;
  logic [DataW-1:0] wdata0, wdata1;
  logic             gnt0, gnt1, rvalid0, rvalid1;
  logic [DataW-1:0] rdata;
  logic             ramWe;
  logic [AddrW-1:0] ramAddr;
  logic [DataW-1:0] ramWData, ramRData;
  logic [1:0]       owner;
  logic             lockErr;
  logic             memClear;
  logic [DataW-1:0] ramMem [RamD];

  typedef struct {
    bit               rst;
    bit               req0, we0, lock0;
    logic [AddrW-1:0] addr0;
    logic [DataW-1:0] wdata0;
    bit               req1, we1, lock1;
    logic [AddrW-1:0] addr1;
    logic [DataW-1:0] wdata1;
    bit               eg0, eg1;
    logic [1:0]       eOwner;
  } vec_t;

  typedef struct {
    int               due;
    int               who;
    logic [DataW-1:0] data;
  } rd_t;

  // Reference model state: who owns the RAM, who was served last, how long
  // the owner has been idle, the expected RAM command and pending reads.
  int               mOwner, mLast, mIdle, mG, cyc;
  logic             mRamWe, mLockErr;
  logic [AddrW-1:0] mRamAddr;
  logic [DataW-1:0] mRamWData;
  logic [DataW-1:0] refMem [RamD];
  rd_t              rdQ[$];

  // Last sampled DUT outputs, used by the hand-written sequences.
  logic             sG0, sG1, sRv0, sRv1, sRamWe, sLockErr;
  logic [AddrW-1:0] sRamAddr;
  logic [DataW-1:0] sRdata;
  logic [1:0]       sOwner;

  int nCompared, nMismatched;
  vec_t tab[14];
  vec_t v;

  ram_port_arbiter #(
    .data_w(DataW), .ram_d(RamD), .LOCK_TIMEOUT(LockTimeout)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .lock0_i(lock0), .lock1_i(lock1),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
    .rdata_o(rdata), .ram_we_o(ramWe), .ram_addr_o(ramAddr),
    .ram_w_data_o(ramWData), .ram_r_data_i(ramRData),
    .owner_o(owner), .lock_err_o(lockErr)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural single-port RAM with one-cycle synchronous read.
  always @(posedge clk) begin
    if (memClear) begin
      for (int i = 0; i < RamD; i++) ramMem[i] <= '0;
    end else if (ramWe) begin
      ramMem[ramAddr] <= ramWData;
    end
    ramRData <= ramMem[ramAddr];
  end

  // Hard stop in case something wedges the stimulus loops.
  initial begin
    #500000;
    $display("[TB] FAIL global timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] timeout");
  end

  task automatic compare(string name, logic [31:0] act, logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(bit r0, bit w0, int a0, logic [DataW-1:0] d0, bit l0,
                              bit r1, bit w1, int a1, logic [DataW-1:0] d1, bit l1,
                              bit eg0 = 1'b0, bit eg1 = 1'b0, logic [1:0] eo = 2'b00);
    vec_t t;
    t.rst = 1'b0;
    t.req0 = r0; t.we0 = w0; t.addr0 = AddrW'(a0); t.wdata0 = d0; t.lock0 = l0;
    t.req1 = r1; t.we1 = w1; t.addr1 = AddrW'(a1); t.wdata1 = d1; t.lock1 = l1;
    t.eg0 = eg0; t.eg1 = eg1; t.eOwner = eo;
    return t;
  endfunction

  task automatic applyStimulus(input vec_t t);
    rst = t.rst;
    req0 = t.req0; we0 = t.we0; addr0 = t.addr0; wdata0 = t.wdata0; lock0 = t.lock0;
    req1 = t.req1; we1 = t.we1; addr1 = t.addr1; wdata1 = t.wdata1; lock1 = t.lock1;
  endtask

  task automatic modelReset();
    mOwner = 0; mLast = 1; mIdle = 0;
    mRamWe = 1'b0; mRamAddr = '0; mRamWData = '0; mLockErr = 1'b0;
    rdQ.delete();
  endtask

  // Who should win this cycle: the lock owner only, otherwise the lone
  // requester, otherwise whoever was not served last. -1 means nobody.
  function automatic int modelGrant();
    if (mOwner == 1) return req0 ? 0 : -1;
    if (mOwner == 2) return req1 ? 1 : -1;
    if (req0 && req1) return (mLast == 1) ? 0 : 1;
    if (req0) return 0;
    if (req1) return 1;
    return -1;
  endfunction

  // Advance the reference model across one clock edge.
  task automatic modelUpdate();
    logic             w;
    logic [AddrW-1:0] a;
    logic [DataW-1:0] d;
    bit               lk;
    int               own;
    rd_t              item;
    if (rst) begin
      modelReset();
      cyc++;
      return;
    end
    mLockErr = 1'b0;
    if (mG >= 0) begin
      w = (mG == 0) ? we0 : we1;
      a = (mG == 0) ? addr0 : addr1;
      d = (mG == 0) ? wdata0 : wdata1;
      mRamWe = w; mRamAddr = a; mRamWData = d; mLast = mG;
      if (w) begin
        refMem[a] = d;
      end else begin
        item.due = cyc + 2; item.who = mG; item.data = refMem[a];
        rdQ.push_back(item);
      end
    end else begin
      mRamWe = 1'b0;
    end
    if (mOwner == 0) begin
      if (mG == 0 && lock0)      mOwner = 1;
      else if (mG == 1 && lock1) mOwner = 2;
      mIdle = 0;
    end else begin
      own = mOwner - 1;
      lk = (own == 0) ? lock0 : lock1;
      if (!lk) begin
        mOwner = 0; mIdle = 0;
      end else if (mG >= 0) begin
        mIdle = 0;
      end else begin
        mIdle++;
        if (mIdle >= LockTimeout) begin
          mOwner = 0; mIdle = 0; mLockErr = 1'b1; mLast = own;
        end
      end
    end
    cyc++;
  endtask

  task automatic checkOutput();
    bit               ev0, ev1;
    logic [DataW-1:0] ed;
    ev0 = 1'b0; ev1 = 1'b0; ed = '0;
    foreach (rdQ[i]) begin
      if (rdQ[i].due == cyc) begin
        if (rdQ[i].who == 0) ev0 = 1'b1;
        else                 ev1 = 1'b1;
        ed = rdQ[i].data;
      end
    end
    sG0 = gnt0; sG1 = gnt1; sRv0 = rvalid0; sRv1 = rvalid1; sRdata = rdata;
    sRamWe = ramWe; sRamAddr = ramAddr; sOwner = owner; sLockErr = lockErr;
    compare("gnt0", 32'(gnt0), 32'(mG == 0));
    compare("gnt1", 32'(gnt1), 32'(mG == 1));
    compare("ram_we", 32'(ramWe), 32'(mRamWe));
    compare("ram_addr", 32'(ramAddr), 32'(mRamAddr));
    compare("ram_w_data", ramWData, mRamWData);
    compare("owner", 32'(owner), 32'(mOwner));
    compare("lock_err", 32'(lockErr), 32'(mLockErr));
    compare("rvalid0", 32'(rvalid0), 32'(ev0));
    compare("rvalid1", 32'(rvalid1), 32'(ev1));
    if (ev0 || ev1) compare("rdata", rdata, ed);
    while (rdQ.size() > 0 && rdQ[0].due <= cyc) void'(rdQ.pop_front());
  endtask

  // One cycle: inputs are already driven just after a rising edge.
  task automatic stepCycle();
    mG = modelGrant();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  // Main sequence: reset, vector table, corner sequences, random traffic.
  initial begin
    nCompared = 0; nMismatched = 0; cyc = 0;
    for (int i = 0; i < RamD; i++) refMem[i] = '0;
    v = mk(0, 0, 0, '0, 0, 0, 0, 0, '0, 0);
    applyStimulus(v);
    rst = 1'b1; memClear = 1'b1;
    repeat (3) @(posedge clk);
    modelReset();
    #1;
    rst = 1'b0; memClear = 1'b0;

    // Reset state.
    stepCycle();
    compare("reset owner", 32'(sOwner), 32'd0);
    compare("reset ram_we", 32'(sRamWe), 32'd0);
    compare("reset ram_addr", 32'(sRamAddr), 32'd0);
    compare("reset rvalid", 32'({sRv0, sRv1}), 32'd0);
    compare("reset lock_err", 32'(sLockErr), 32'd0);

    // Round-robin with both requesting, then a locked read burst by req1.
    tab[0]  = mk(1, 1, 2, 32'hA2, 0, 1, 1, 3, 32'hB3, 0, 1, 0, 2'b00);
    tab[1]  = mk(1, 1, 4, 32'hA4, 0, 1, 1, 3, 32'hB3, 0, 0, 1, 2'b00);
    tab[2]  = mk(1, 1, 4, 32'hA4, 0, 1, 1, 5, 32'hB5, 0, 1, 0, 2'b00);
    tab[3]  = mk(1, 1, 6, 32'hA6, 0, 1, 1, 5, 32'hB5, 0, 0, 1, 2'b00);
    tab[4]  = mk(1, 1, 6, 32'hA6, 0, 1, 1, 7, 32'hB7, 0, 1, 0, 2'b00);
    tab[5]  = mk(1, 1, 8, 32'hA8, 0, 1, 1, 7, 32'hB7, 0, 0, 1, 2'b00);
    tab[6]  = mk(1, 1, 8, 32'hA8, 0, 0, 0, 0, '0, 0, 1, 0, 2'b00);
    tab[7]  = mk(1, 0, 9, '0, 0, 1, 0, 2, '0, 1, 0, 1, 2'b00);
    tab[8]  = mk(1, 0, 9, '0, 0, 1, 0, 3, '0, 1, 0, 1, 2'b10);
    tab[9]  = mk(1, 0, 9, '0, 0, 1, 0, 4, '0, 1, 0, 1, 2'b10);
    tab[10] = mk(1, 0, 9, '0, 0, 1, 0, 5, '0, 0, 0, 1, 2'b10);
    tab[11] = mk(1, 0, 9, '0, 0, 0, 0, 0, '0, 0, 1, 0, 2'b00);
    tab[12] = mk(0, 0, 0, '0, 0, 0, 0, 0, '0, 0, 0, 0, 2'b00);
    tab[13] = mk(0, 0, 0, '0, 0, 0, 0, 0, '0, 0, 0, 0, 2'b00);
    foreach (tab[i]) begin
      applyStimulus(tab[i]);
      stepCycle();
      compare($sformatf("tab%0d gnt0", i), 32'(sG0), 32'(tab[i].eg0));
      compare($sformatf("tab%0d gnt1", i), 32'(sG1), 32'(tab[i].eg1));
      compare($sformatf("tab%0d owner", i), 32'(sOwner), 32'(tab[i].eOwner));
    end

    // Single read between two writes from the other requester.
    applyStimulus(mk(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, '0, 0));
    stepCycle();
    compare("A write5 gnt0", 32'(sG0), 32'd1);
    applyStimulus(mk(1, 1, 6, 32'h1234, 0, 1, 0, 5, '0, 0));
    stepCycle();
    compare("A read gnt1", 32'(sG1), 32'd1);
    compare("A read gnt0", 32'(sG0), 32'd0);
    compare("A ram_we", 32'(sRamWe), 32'd1);
    compare("A ram_addr", 32'(sRamAddr), 32'd5);
    applyStimulus(mk(1, 1, 6, 32'h1234, 0, 0, 0, 0, '0, 0));
    stepCycle();
    compare("A write6 gnt0", 32'(sG0), 32'd1);
    applyStimulus(mk(0, 0, 0, '0, 0, 0, 0, 0, '0, 0));
    stepCycle();
    compare("A rvalid1", 32'(sRv1), 32'd1);
    compare("A rdata", sRdata, 32'hDEADBEEF);

    // Watchdog: req0 locks then goes quiet while req1 waits.
    applyStimulus(mk(1, 0, 1, '0, 1, 0, 0, 0, '0, 0));
    stepCycle();
    compare("B lock gnt0", 32'(sG0), 32'd1);
    for (int k = 1; k <= LockTimeout; k++) begin
      applyStimulus(mk(0, 0, 0, '0, 1, 1, 0, 3, '0, 0));
      stepCycle();
      compare($sformatf("B idle%0d gnt1", k), 32'(sG1), 32'd0);
      compare($sformatf("B idle%0d owner", k), 32'(sOwner), 32'd1);
    end
    applyStimulus(mk(0, 0, 0, '0, 0, 1, 0, 3, '0, 0));
    stepCycle();
    compare("B release owner", 32'(sOwner), 32'd0);
    compare("B lock_err", 32'(sLockErr), 32'd1);
    compare("B pending gnt1", 32'(sG1), 32'd1);
    applyStimulus(mk(0, 0, 0, '0, 0, 0, 0, 0, '0, 0));
    stepCycle();
    compare("B lock_err clears", 32'(sLockErr), 32'd0);

    // Reset the cycle after a locked read grant.
    applyStimulus(mk(1, 0, 2, '0, 1, 0, 0, 0, '0, 0));
    stepCycle();
    compare("C read gnt0", 32'(sG0), 32'd1);
    v = mk(0, 0, 0, '0, 0, 0, 0, 0, '0, 0);
    v.rst = 1'b1;
    applyStimulus(v);
    stepCycle();
    applyStimulus(mk(1, 0, 3, '0, 0, 1, 0, 4, '0, 0));
    stepCycle();
    compare("C no rvalid0", 32'(sRv0), 32'd0);
    compare("C ram_we", 32'(sRamWe), 32'd0);
    compare("C ram_addr", 32'(sRamAddr), 32'd0);
    compare("C owner", 32'(sOwner), 32'd0);
    compare("C tie gnt0", 32'(sG0), 32'd1);
    applyStimulus(mk(0, 0, 0, '0, 0, 1, 0, 4, '0, 0));
    stepCycle();
    compare("C then gnt1", 32'(sG1), 32'd1);
    applyStimulus(mk(0, 0, 0, '0, 0, 0, 0, 0, '0, 0));
    stepCycle();

    // Back-to-back accesses from req0: three writes then three reads.
    for (int k = 0; k < 8; k++) begin
      if (k < 3)      applyStimulus(mk(1, 1, 10 + k, 32'hC0DE0000 + 32'(10 + k), 0, 0, 0, 0, '0, 0));
      else if (k < 6) applyStimulus(mk(1, 0, 7 + k, '0, 0, 0, 0, 0, '0, 0));
      else            applyStimulus(mk(0, 0, 0, '0, 0, 0, 0, 0, '0, 0));
      stepCycle();
      if (k < 6) compare($sformatf("D%0d gnt0", k), 32'(sG0), 32'd1);
      if (k == 3 || k == 4) compare($sformatf("D%0d rvalid0", k), 32'(sRv0), 32'd0);
      if (k >= 5) begin
        compare($sformatf("D%0d rvalid0", k), 32'(sRv0), 32'd1);
        compare($sformatf("D%0d rdata", k), sRdata, 32'hC0DE0000 + 32'(5 + k));
      end
    end

    // Randomized traffic with sticky locks, checked by the model.
    applyStimulus(mk(0, 0, 0, '0, 0, 0, 0, 0, '0, 0));
    for (int c = 0; c < 1500; c++) begin
      if (!req0 && $urandom_range(0, 99) < 40) begin
        req0 = 1'b1; we0 = 1'($urandom_range(0, 1));
        addr0 = AddrW'($urandom_range(0, 15)); wdata0 = $urandom;
      end
      if (!req1 && $urandom_range(0, 99) < 40) begin
        req1 = 1'b1; we1 = 1'($urandom_range(0, 1));
        addr1 = AddrW'($urandom_range(0, 15)); wdata1 = $urandom;
      end
      if ($urandom_range(0, 99) < 8) lock0 = ~lock0;
      if ($urandom_range(0, 99) < 8) lock1 = ~lock1;
      stepCycle();
      if (mG == 0) req0 = 1'b0;
      if (mG == 1) req1 = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
